// File: rtl/sd_spi_pkg.sv
//------------------------------------------------------------------------------
// Module  : sd_spi_pkg
// Brief   : Shared types and constants for the SD SPI-mode command path.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_END  = 3'd4,
        ST_PAD  = 3'd5,
        ST_DONE = 3'd6
    } sd_cmd_state_t;

    localparam int FRAME_BITS = 48;
    localparam int HDR_BITS   = 40;
    localparam int CRC_BITS   = 7;
    localparam int PAD_BITS   = 8;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;

endpackage

`default_nettype wire

// File: rtl/crc_7.sv
//------------------------------------------------------------------------------
// Module  : crc_7
// Brief   : Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, synchronous clear.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc_7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic       dat_i,
    output logic [6:0] crc_o
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb  = r_crc[6] ^ dat_i;
    assign crc_o = r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= '0;
        end else if (valid_i) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ {3'b000, w_fb, 2'b00, w_fb};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_cmd_tx.sv
//------------------------------------------------------------------------------
// Module  : sd_cmd_tx
// Brief   : Serialises a 48-bit SD SPI-mode command frame with on-the-fly CRC7.
//           Define SD_CMD_TX_PAD_EN to append an 8-bit Ncr dummy byte.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sd_cmd_tx
    import sd_spi_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] cmd_arg_i,
    input  logic        bit_stb_i,
    output logic        mosi_o,
    output logic        cs_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [6:0]  crc_o
);

    sd_cmd_state_t        r_state;
    sd_cmd_state_t        w_next;
    logic [HDR_BITS-1:0]  r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [CRC_BITS-1:0]  r_crc_out;
    logic [CRC_BITS-1:0]  w_crc;
    logic                 w_crc_clr;
    logic                 w_crc_rst;
    logic                 w_crc_vld;
    logic                 w_mosi;
    logic                 w_cs_n;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_ready;

    assign w_crc_rst = rst | w_crc_clr;

    crc_7 u_crc_7 (
        .clk     (clk),
        .rst     (w_crc_rst),
        .valid_i (w_crc_vld),
        .dat_i   (r_shift[HDR_BITS-1]),
        .crc_o   (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mosi    = 1'b1;
        w_cs_n    = 1'b1;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_ready   = 1'b0;
        w_crc_vld = 1'b0;
        w_crc_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy  = 1'b0;
                w_ready = ~rst;
                if (cmd_valid_i && w_ready) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cs_n    = 1'b0;
                w_crc_clr = 1'b1;
                w_next    = ST_DATA;
            end
            ST_DATA: begin
                w_cs_n = 1'b0;
                w_mosi = r_shift[HDR_BITS-1];
                if (bit_stb_i) begin
                    w_crc_vld = 1'b1;
                    if (r_cnt == CNT_W'(HDR_BITS - 1)) begin
                        w_next = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                // CRC engine is idle here, so its output is the frozen frame CRC
                w_cs_n = 1'b0;
                w_mosi = w_crc[3'(CRC_BITS - 1) - r_cnt[2:0]];
                if (bit_stb_i && (r_cnt == CNT_W'(CRC_BITS - 1))) begin
                    w_next = ST_END;
                end
            end
            ST_END: begin
                w_cs_n = 1'b0;
                if (bit_stb_i) begin
`ifdef SD_CMD_TX_PAD_EN
                    w_next = ST_PAD;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_PAD: begin
`ifdef SD_CMD_TX_PAD_EN
                w_cs_n = 1'b0;
                if (bit_stb_i && (r_cnt == CNT_W'(PAD_BITS - 1))) begin
                    w_next = ST_DONE;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change so each phase counts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_crc_out <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_shift <= {2'b01, cmd_idx_i, cmd_arg_i};
            end else if (w_crc_vld) begin
                r_shift <= {r_shift[HDR_BITS-2:0], 1'b0};
            end

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (bit_stb_i && ((r_state == ST_DATA) || (r_state == ST_CRC) ||
                                       (r_state == ST_PAD))) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
                r_crc_out <= w_crc;
            end
        end
    end

    assign cmd_ready_o = w_ready;
    assign mosi_o      = w_mosi;
    assign cs_n_o      = w_cs_n;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign crc_o       = r_crc_out;

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_sd_cmd_tx
// Brief   : Self-checking bench for sd_cmd_tx against a frame-array model.
//           Honours SD_CMD_TX_PAD_EN for the padded frame length.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sd_cmd_tx;
    import sd_spi_pkg::*;

`ifdef SD_CMD_TX_PAD_EN
    localparam int NB = 56;
`else
    localparam int NB = 48;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [5:0]  cmd_idx_i = '0;
    logic [31:0] cmd_arg_i = '0;
    logic        bit_stb_i = 1'b0;
    logic        mosi_o;
    logic        cs_n_o;
    logic        busy_o;
    logic        done_o;
    logic [6:0]  crc_o;

    sd_cmd_tx #(.CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_idx_i   (cmd_idx_i),
        .cmd_arg_i   (cmd_arg_i),
        .bit_stb_i   (bit_stb_i),
        .mosi_o      (mosi_o),
        .cs_n_o      (cs_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .crc_o       (crc_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 load, 2 shifting frame bits, 3 done
    int          m_phase = 0;
    int          m_idx = 0;
    logic        m_frame [0:55];
    logic [6:0]  m_crc = '0;
    logic [6:0]  m_fcrc = '0;
    int          m_done_cnt = 0;
    logic [55:0] cap = '0;
    int          cap_n = 0;
    int          stb_mode = 3;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [39:0] h);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ h[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [55:0] exp_stream(input logic [47:0] f);
        if (NB == 56) return {f, 8'hFF};
        return {8'h00, f};
    endfunction

    always @(negedge clk) begin
        logic e_ready, e_mosi, e_csn, e_busy, e_done;
        logic [6:0]  e_crc;
        logic [39:0] h;
        logic [6:0]  c;
        if (rst) begin
            e_ready = 0; e_mosi = 1; e_csn = 1; e_busy = 0; e_done = 0; e_crc = '0;
        end else begin
            e_crc = m_crc;
            case (m_phase)
                0:       begin e_ready = 1; e_mosi = 1; e_csn = 1; e_busy = 0; e_done = 0; end
                1:       begin e_ready = 0; e_mosi = 1; e_csn = 0; e_busy = 1; e_done = 0; end
                2:       begin e_ready = 0; e_mosi = m_frame[m_idx]; e_csn = 0; e_busy = 1; e_done = 0; end
                default: begin e_ready = 0; e_mosi = 1; e_csn = 1; e_busy = 1; e_done = 1; end
            endcase
        end
        chk("ready", cmd_ready_o, e_ready);
        chk("mosi",  mosi_o,      e_mosi);
        chk("cs_n",  cs_n_o,      e_csn);
        chk("busy",  busy_o,      e_busy);
        chk("done",  done_o,      e_done);
        chk("crc",   crc_o,       e_crc);

        if (!rst && m_phase == 2 && bit_stb_i) begin
            cap   = {cap[54:0], mosi_o};
            cap_n = cap_n + 1;
        end

        if (rst) begin
            m_phase = 0;
            m_crc   = '0;
        end else begin
            case (m_phase)
                0: if (cmd_valid_i) begin
                    h = {2'b01, cmd_idx_i, cmd_arg_i};
                    c = crc7_of(h);
                    for (int i = 0; i < 40; i++) m_frame[i] = h[39-i];
                    for (int i = 0; i < 7; i++)  m_frame[40+i] = c[6-i];
                    for (int i = 47; i < 56; i++) m_frame[i] = 1'b1;
                    m_fcrc  = c;
                    m_phase = 1;
                    cap     = '0;
                    cap_n   = 0;
                end
                1: begin m_phase = 2; m_idx = 0; end
                2: if (bit_stb_i) begin
                    if (m_idx == NB - 1) begin
                        m_phase = 3;
                        m_crc   = m_fcrc;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
                default: begin m_phase = 0; m_done_cnt = m_done_cnt + 1; end
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (stb_mode)
                0:       bit_stb_i = (cyc % 4 == 0);
                1:       bit_stb_i = 1'b1;
                2:       bit_stb_i = ($urandom_range(0, 2) == 0);
                default: bit_stb_i = 1'b0;
            endcase
            cyc++;
        end
    end

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg);
        bit hs;
        hs = 0;
        cmd_idx_i = idx; cmd_arg_i = arg; cmd_valid_i = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(posedge clk); #2;
            if (m_phase != 0) hs = 1;
        end
        chk("handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && m_done_cnt == d0; i++) begin
            @(posedge clk); #2;
        end
        chk("frame_done", 64'(m_done_cnt - d0), 64'd1);
    endtask

    task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int mode);
        int d0;
        stb_mode = mode;
        d0 = m_done_cnt;
        start_cmd(idx, arg);
        cmd_valid_i = 1'b0;
        wait_done(d0);
    endtask

    task automatic check_frame(input string tag, input logic [47:0] f, input logic [6:0] c);
        chk({tag, "_stream"}, cap, exp_stream(f));
        chk({tag, "_nbits"}, 64'(cap_n), 64'(NB));
        chk({tag, "_crc_o"}, crc_o, c);
    endtask

    initial begin
        int d0;
        chk("model_crc_cmd0",  crc7_of({2'b01, CMD0,  32'h0}),   7'h4A);
        chk("model_crc_cmd8",  crc7_of({2'b01, CMD8,  32'h1AA}), 7'h43);
        chk("model_crc_cmd17", crc7_of({2'b01, CMD17, 32'h0}),   7'h2A);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #2;
        chk("reset_ready", cmd_ready_o, 1'b1);
        chk("reset_crc",   crc_o, 7'h00);

        run_frame(CMD0, 32'h0, 0);
        check_frame("cmd0", 48'h40_0000_0000_95, 7'h4A);

        run_frame(CMD8, 32'h0000_01AA, 2);
        check_frame("cmd8", 48'h48_0000_01AA_87, 7'h43);

        run_frame(CMD17, 32'h0, 1);
        check_frame("cmd17", 48'h51_0000_0000_55, 7'h2A);

        // valid held high across a whole frame, second command queued on the pins
        stb_mode = 2;
        d0 = m_done_cnt;
        start_cmd(CMD8, $urandom);
        cmd_idx_i = CMD0;
        cmd_arg_i = 32'h0;
        wait_done(d0);
        d0 = m_done_cnt;
        for (int i = 0; i < 20 && m_phase == 0; i++) begin @(posedge clk); #2; end
        cmd_valid_i = 1'b0;
        wait_done(d0);
        check_frame("held_cmd0", 48'h40_0000_0000_95, 7'h4A);

        // abort a CMD8 after 20 strobes
        stb_mode = 0;
        start_cmd(CMD8, 32'h0000_01AA);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 500 && !(m_phase == 2 && m_idx == 20); i++) begin
            @(posedge clk); #2;
        end
        chk("abort_reached", 64'(m_idx), 64'd20);
        d0 = m_done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("abort_mosi", mosi_o, 1'b1);
        chk("abort_cs_n", cs_n_o, 1'b1);
        chk("abort_busy", busy_o, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #2 chk("abort_no_done", 64'(m_done_cnt - d0), 64'd0);

        run_frame(CMD0, 32'h0, 2);
        check_frame("post_abort_cmd0", 48'h40_0000_0000_95, 7'h4A);

        for (int k = 0; k < 6; k++) begin
            run_frame(6'($urandom), $urandom, 2);
            chk("rand_nbits", 64'(cap_n), 64'(NB));
        end

        stb_mode = 3;
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
